rv32_exec_alu: RTL and testbench

- Execute-stage arithmetic block for the RV32I 5-stage pipeline.
- Decodes the instruction's immediate combinationally.
- Computes the ALU result and the branch-taken flag, and registers both with a one-cycle latency into the E/M boundary.
- Operand selection (PC vs rs1, rs2 vs imm vs 4) and the LUI override stay in the core.

---
 rtl/rv32_pkg.sv | 41 ++++
 rtl/rv32_imm_gen.sv | 35 +++
 rtl/rv32_exec_alu.sv | 119 +++++++++++
 tb/tb_rv32_exec_alu.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values and immediate formats.
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate decoder: instruction word to sign-extended immediate.
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  imm_fmt_e fmt;

  always_comb begin
    fmt = IMM_NONE;
    case (instr[6:0])
      OP_IMM, LOAD, JALR, SYSTEM, FENCE: fmt = IMM_I;
      STORE:                             fmt = IMM_S;
      BRANCH:                            fmt = IMM_B;
      LUI, AUIPC:                        fmt = IMM_U;
      JAL:                               fmt = IMM_J;
      default:                           fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32_exec_alu.sv
// RV32I execute-stage ALU with branch resolution and a one-cycle output register.
// Define ALU_SHARED_ADDER_EN to share one 33-bit add/sub between ADD/SUB and all compares.
module rv32_exec_alu
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [31:0]     imm,
  output logic [XLEN-1:0] result,
  output logic            take_b,
  output logic            out_valid
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [4:0]      shamt;
  logic            is_alu;
  logic            is_branch;
  logic            is_sub;
  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] sub_res;
  logic [XLEN-1:0] addr_sum;
  logic            lt;
  logic            ltu;
  logic            eq;
  logic [XLEN-1:0] alu_res;
  logic            br_take;

  assign opcode    = instr[6:0];
  assign f3        = instr[14:12];
  assign shamt     = in_b[4:0];
  assign is_alu    = (opcode == OP) || (opcode == OP_IMM);
  assign is_branch = (opcode == BRANCH);
  assign is_sub    = (opcode == OP) && (f3 == F3_ADD) && instr[30];

  rv32_imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

`ifdef ALU_SHARED_ADDER_EN
  logic            use_sub;
  logic [XLEN:0]   sum33;
  logic [XLEN-1:0] b_op;

  // Compares always subtract; branch/link/address sums use their own adder so
  // the shared unit can hold a - b for the branch compare in the same cycle.
  assign use_sub = is_branch || is_sub ||
                   (is_alu && ((f3 == F3_SLT) || (f3 == F3_SLTU)));
  assign b_op    = use_sub ? ~in_b : in_b;
  assign sum33   = {1'b0, in_a} + {1'b0, b_op} + {{XLEN{1'b0}}, use_sub};
  assign add_res = sum33[XLEN-1:0];
  assign sub_res = sum33[XLEN-1:0];
  assign ltu     = ~sum33[XLEN];
  assign lt      = (in_a[XLEN-1] ^ in_b[XLEN-1]) ? in_a[XLEN-1] : sum33[XLEN-1];
  assign eq      = (sum33[XLEN-1:0] == '0);
  assign addr_sum = in_a + in_b;
`else
  assign add_res  = in_a + in_b;
  assign sub_res  = in_a - in_b;
  assign addr_sum = add_res;
  assign lt       = ($signed(in_a) < $signed(in_b));
  assign ltu      = (in_a < in_b);
  assign eq       = (in_a == in_b);
`endif

  always_comb begin
    alu_res = addr_sum;
    if (is_alu) begin
      case (f3)
        F3_ADD:  alu_res = is_sub ? sub_res : add_res;
        F3_SLL:  alu_res = in_a << shamt;
        F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt};
        F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, ltu};
        F3_XOR:  alu_res = in_a ^ in_b;
        F3_SR:   alu_res = instr[30] ? XLEN'($signed(in_a) >>> shamt) : (in_a >> shamt);
        F3_OR:   alu_res = in_a | in_b;
        F3_AND:  alu_res = in_a & in_b;
        default: alu_res = add_res;
      endcase
    end
  end

  always_comb begin
    br_take = 1'b0;
    if (is_branch) begin
      case (f3)
        F3_BEQ:  br_take = eq;
        F3_BNE:  br_take = ~eq;
        F3_BLT:  br_take = lt;
        F3_BGE:  br_take = ~lt;
        F3_BLTU: br_take = ltu;
        F3_BGEU: br_take = ~ltu;
        default: br_take = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      result    <= '0;
      take_b    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= alu_res;
        take_b <= br_take;
      end
    end
  end

endmodule

// File: tb/tb_rv32_exec_alu.sv
// Directed self-checking bench for rv32_exec_alu (valid with or without ALU_SHARED_ADDER_EN).
module tb_rv32_exec_alu;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;
  logic        out_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rv32_exec_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .instr     (instr),
    .in_a      (in_a),
    .in_b      (in_b),
    .imm       (imm),
    .result    (result),
    .take_b    (take_b),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // R/I-style encoding with rs1=x1, rs2=x2, rd=x3; b30 lands in funct7[5].
  function automatic logic [31:0] enc(input logic b30, input logic [2:0] f3, input logic [6:0] opc);
    return {1'b0, b30, 5'b0, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    instr    = ins;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                    input string tag, input logic [31:0] exp_res, input logic exp_take);
    step(1'b1, ins, a, b);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_take"}, {31'b0, take_b}, {31'b0, exp_take});
    check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    in_a     = '0;
    in_b     = '0;
    @(posedge clk);
    #1;

    // Reset wins over a valid input.
    step(1'b1, enc(1'b0, 3'b000, 7'b0110011), 32'd5, 32'd6);
    check("rst_res", result, 32'h0);
    check("rst_take", {31'b0, take_b}, 32'h0);
    check("rst_ov", {31'b0, out_valid}, 32'h0);
    resetn = 1'b1;
    step(1'b0, enc(1'b0, 3'b000, 7'b0110011), 32'd5, 32'd6);
    check("rel_ov", {31'b0, out_valid}, 32'h0);
    check("rel_res", result, 32'h0);

    // Arithmetic
    op(enc(1'b0, 3'b000, 7'b0110011), 32'h7FFFFFFF, 32'h1, "add_ovf", 32'h80000000, 1'b0);
    op(enc(1'b1, 3'b000, 7'b0110011), 32'h0, 32'h1, "sub", 32'hFFFFFFFF, 1'b0);
    op(enc(1'b1, 3'b000, 7'b0010011), 32'd10, 32'd3, "addi_b30", 32'd13, 1'b0);

    // Hold with in_valid low
    step(1'b0, enc(1'b0, 3'b100, 7'b0110011), 32'h55, 32'hAA);
    check("hold_res", result, 32'd13);
    check("hold_ov", {31'b0, out_valid}, 32'h0);

    // Shifts
    op(enc(1'b1, 3'b101, 7'b0110011), 32'h80000000, 32'h1F, "sra31", 32'hFFFFFFFF, 1'b0);
    op(enc(1'b0, 3'b101, 7'b0110011), 32'h80000000, 32'h1F, "srl31", 32'h00000001, 1'b0);
    op(enc(1'b0, 3'b001, 7'b0110011), 32'h1, 32'h20, "sll32", 32'h00000001, 1'b0);
    op(enc(1'b0, 3'b101, 7'b0110011), 32'hDEADBEEF, 32'h0, "srl0", 32'hDEADBEEF, 1'b0);

    // Compares and logic
    op(enc(1'b0, 3'b010, 7'b0110011), 32'hFFFFFFFF, 32'h1, "slt", 32'h1, 1'b0);
    op(enc(1'b0, 3'b011, 7'b0110011), 32'hFFFFFFFF, 32'h1, "sltu", 32'h0, 1'b0);
    op(enc(1'b0, 3'b010, 7'b0110011), 32'h80000000, 32'h0, "slt_min", 32'h1, 1'b0);
    op(enc(1'b0, 3'b110, 7'b0110011), 32'hF0F00000, 32'h0000F0F0, "or", 32'hF0F0F0F0, 1'b0);
    op(enc(1'b0, 3'b111, 7'b0110011), 32'hFF00FF00, 32'h0FF00FF0, "and", 32'h0F000F00, 1'b0);

    // Branches: result is still a + b
    op(enc(1'b0, 3'b100, 7'b1100011), 32'hFFFFFFFF, 32'h1, "blt", 32'h0, 1'b1);
    op(enc(1'b0, 3'b111, 7'b1100011), 32'hFFFFFFFF, 32'h1, "bgeu", 32'h0, 1'b1);
    op(enc(1'b0, 3'b000, 7'b1100011), 32'hFFFFFFFF, 32'h1, "beq_nt", 32'h0, 1'b0);
    op(enc(1'b0, 3'b000, 7'b1100011), 32'd7, 32'd7, "beq_t", 32'd14, 1'b1);
    op(enc(1'b0, 3'b011, 7'b1100011), 32'd7, 32'd7, "br_f3_3", 32'd14, 1'b0);
    op(enc(1'b0, 3'b000, 7'b0110011), 32'd7, 32'd7, "add_eq_nt", 32'd14, 1'b0);
    op(enc(1'b0, 3'b010, 7'b0000011), 32'd100, 32'd8, "lw_addr", 32'd108, 1'b0);

    // Immediate decode (combinational)
    in_valid = 1'b0;
    instr = 32'hFFF00093; #1; check("imm_addi", imm, 32'hFFFFFFFF);
    instr = 32'h123450B7; #1; check("imm_lui", imm, 32'h12345000);
    instr = 32'hFFDFF06F; #1; check("imm_jal", imm, 32'hFFFFFFFC);
    instr = 32'h00112423; #1; check("imm_sw", imm, 32'h00000008);
    instr = 32'hFE208CE3; #1; check("imm_beq", imm, 32'hFFFFFFF8);
    instr = 32'h002081B3; #1; check("imm_rtype", imm, 32'h00000000);
    resetn = 1'b0; #1; check("imm_in_rst", imm, 32'h00000000);
    instr = 32'hFFF00093; #1; check("imm_in_rst2", imm, 32'hFFFFFFFF);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back
    op(enc(1'b0, 3'b000, 7'b0110011), 32'd3, 32'd4, "b2b_add", 32'd7, 1'b0);
    op(enc(1'b0, 3'b100, 7'b0110011), 32'hF0, 32'hFF, "b2b_xor", 32'h0F, 1'b0);
    op(enc(1'b0, 3'b001, 7'b1100011), 32'd1, 32'd2, "b2b_bne", 32'd3, 1'b1);
    step(1'b0, '0, '0, '0);
    check("b2b_end_ov", {31'b0, out_valid}, 32'h0);
    check("b2b_end_res", result, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
